axi_rd_sram: RTL and testbench

AXI4 read-channel responder (AR/R only) fronting a synchronous-read instruction SRAM. It is the slave end of the fetch unit's read port and accepts that unit's requests unchanged: single beat, FIXED burst, 4-byte size, reset PC 0x2000_0000. It also serves multi-beat FIXED/INCR/WRAP bursts, flags illegal requests with SLVERR, and can insert a configurable response delay for latency testing.

---
 rtl/axi_pkg.sv | 19 +
 rtl/axi_burst_addr.sv | 57 +++++
 rtl/axi_rd_sram.sv | 138 +++++++++++++
 tb/tb_axi_rd_sram.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and read-responder state type, also used by the
// planned write responder.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REQ,
        RESP
    } rd_state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI burst address stepping plus transaction and beat
// legality checks against a single memory window.
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h2000_0000,
    parameter int                    MEM_WORDS  = 16384,
    parameter int                    MAX_SIZE   = 2
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_len,
    input  logic [2:0]            i_size,
    input  logic [1:0]            i_burst,
    output logic [ADDR_WIDTH-1:0] o_next_addr,
    output logic                  o_txn_err,
    output logic                  o_beat_err
);

    localparam int AW1 = ADDR_WIDTH + 1;
    // One extra bit so the end of the window cannot overflow the compare.
    localparam logic [AW1-1:0] LIMIT = {1'b0, BASE_ADDR} + AW1'(4 * MEM_WORDS);

    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_sum;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;
    logic                  w_wrap_len_ok;

    assign w_incr        = ADDR_WIDTH'(1) << i_size;
    assign w_sum         = i_addr + w_incr;
    assign w_wrap_mask   = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size) - ADDR_WIDTH'(1);
    assign w_wrap_len_ok = (i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15);

    always_comb begin
        o_next_addr = i_addr;
        case (i_burst)
            BURST_INCR: o_next_addr = w_sum;
            BURST_WRAP: o_next_addr = (i_addr & ~w_wrap_mask) | (w_sum & w_wrap_mask);
            default:    o_next_addr = i_addr;
        endcase
    end

    always_comb begin
        o_txn_err = 1'b0;
        if (int'(i_size) > MAX_SIZE)
            o_txn_err = 1'b1;
        if (i_burst == 2'b11)
            o_txn_err = 1'b1;
        if (i_burst == BURST_WRAP && !w_wrap_len_ok)
            o_txn_err = 1'b1;
        if (i_burst == BURST_WRAP && (i_addr & (w_incr - ADDR_WIDTH'(1))) != '0)
            o_txn_err = 1'b1;
    end

    assign o_beat_err = (i_addr < BASE_ADDR) || ({1'b0, i_addr} >= LIMIT);

endmodule

// File: rtl/axi_rd_sram.sv
// AXI4 read-only slave in front of a synchronous-read SRAM: one burst at a
// time, one memory read per beat, optional idle delay before each read.
module axi_rd_sram
    import axi_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h2000_0000,
    parameter int                    MEM_WORDS  = 16384,
    parameter int                    RD_DELAY   = 0,
    parameter int                    MEM_AW     = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [3:0]            arid,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic [ADDR_WIDTH-1:0] araddr,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic [3:0]            rid,
    output logic                  mem_en,
    output logic [MEM_AW-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam rd_state_e  BEAT_START = (RD_DELAY > 0) ? DELAY : REQ;
    localparam logic [7:0] DLY_LOAD   = 8'(RD_DELAY - 1);

    rd_state_e             r_state;
    rd_state_e             w_state_next;
    logic                  r_arready;
    logic [3:0]            r_id;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_beat_cnt;
    logic [7:0]            r_dly_cnt;

    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_last;
    logic                  w_err;
    logic                  w_txn_err;
    logic                  w_beat_err;
    logic [ADDR_WIDTH-1:0] w_next_addr;

    axi_burst_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .MEM_WORDS  (MEM_WORDS),
        .MAX_SIZE   ($clog2(DATA_WIDTH / 8))
    ) u_burst_addr (
        .i_addr      (r_addr),
        .i_len       (r_len),
        .i_size      (r_size),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr),
        .o_txn_err   (w_txn_err),
        .o_beat_err  (w_beat_err)
    );

    assign w_ar_hs = arvalid && r_arready;
    assign w_r_hs  = (r_state == RESP) && rready;
    assign w_last  = (r_beat_cnt == 8'd0);
    assign w_err   = w_txn_err || w_beat_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_ar_hs) w_state_next = BEAT_START;
            DELAY:   if (r_dly_cnt == 8'd0) w_state_next = REQ;
            REQ:     w_state_next = RESP;
            RESP:    if (rready) w_state_next = w_last ? IDLE : BEAT_START;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        arready  = r_arready;
        rvalid   = (r_state == RESP);
        rlast    = rvalid && w_last;
        rresp    = (rvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
        rdata    = (rvalid && !w_err) ? mem_rdata : '0;
        rid      = r_id;
        mem_en   = (r_state == REQ) && !w_err;
        mem_addr = MEM_AW'((r_addr - BASE_ADDR) >> 2);
    end

    // arready only ever rises while IDLE, so acceptance implies IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arready  <= 1'b0;
            r_id       <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_addr     <= '0;
            r_beat_cnt <= '0;
            r_dly_cnt  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_arready  <= 1'b0;
                r_id       <= arid;
                r_len      <= arlen;
                r_size     <= arsize;
                r_burst    <= arburst;
                r_addr     <= araddr;
                r_beat_cnt <= arlen;
                r_dly_cnt  <= DLY_LOAD;
            end else if (r_state == IDLE || (w_r_hs && w_last)) begin
                r_arready <= 1'b1;
            end
            if (r_state == DELAY)
                r_dly_cnt <= r_dly_cnt - 8'd1;
            if (w_r_hs && !w_last) begin
                r_addr     <= w_next_addr;
                r_beat_cnt <= r_beat_cnt - 8'd1;
                r_dly_cnt  <= DLY_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_sram.sv
// Scoreboard bench: instance 0 has no read delay, instance 1 has RD_DELAY=4.
module tb_axi_rd_sram;

    localparam int MEM_AW = 14;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst       [2];
    logic              arvalid   [2];
    logic              arready   [2];
    logic [3:0]        arid      [2];
    logic [7:0]        arlen     [2];
    logic [2:0]        arsize    [2];
    logic [1:0]        arburst   [2];
    logic [31:0]       araddr    [2];
    logic              rvalid    [2];
    logic              rready    [2];
    logic [31:0]       rdata     [2];
    logic [1:0]        rresp     [2];
    logic              rlast     [2];
    logic [3:0]        rid       [2];
    logic              mem_en    [2];
    logic [MEM_AW-1:0] mem_addr  [2];
    logic [31:0]       mem_rdata [2];
    logic [31:0]       mem [16384];

    beat_t             exp_q   [2][$];
    logic [MEM_AW-1:0] exp_mem [2][$];
    int                rdy_mode [2];
    int                tmo_cnt = 0;
    int                tmo_seen = 0;
    int                n_checks = 0;
    int                n_fail = 0;
    int                cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [31:0] r_q;
        axi_rd_sram #(.RD_DELAY(gi * 4)) u_dut (
            .clk       (clk),
            .rst       (rst[gi]),
            .arvalid   (arvalid[gi]),
            .arready   (arready[gi]),
            .arid      (arid[gi]),
            .arlen     (arlen[gi]),
            .arsize    (arsize[gi]),
            .arburst   (arburst[gi]),
            .araddr    (araddr[gi]),
            .rvalid    (rvalid[gi]),
            .rready    (rready[gi]),
            .rdata     (rdata[gi]),
            .rresp     (rresp[gi]),
            .rlast     (rlast[gi]),
            .rid       (rid[gi]),
            .mem_en    (mem_en[gi]),
            .mem_addr  (mem_addr[gi]),
            .mem_rdata (mem_rdata[gi])
        );
        always @(posedge clk) if (mem_en[gi]) r_q <= mem[mem_addr[gi]];
        assign mem_rdata[gi] = r_q;
    end

    // Monitor: drives rready, pops expectations and checks protocol timing.
    int    hs_edge    [2];
    int    post_rst   [2];
    bit    first_pend [2];
    bit    chk_bub    [2];
    bit    chk_ar     [2];
    bit    hold_v     [2];
    bit    rst_seen   [2];
    beat_t hold_b     [2];
    beat_t cur, want;

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            rready[g] = (rdy_mode[g] == 0) ? 1'b1 :
                        (rdy_mode[g] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            cur = '{rdata[g], rresp[g], rlast[g], rid[g]};
            if (rst[g]) begin
                if (!rst_seen[g]) begin
                    n_checks++;
                    if ({arready[g], rvalid[g], rlast[g], rresp[g], rid[g], mem_en[g]} != 10'd0) begin
                        n_fail++;
                        $display("FAIL reset_vals[%0d] got arready=%b rvalid=%b rlast=%b rresp=%b rid=%h mem_en=%b, want all 0",
                                 g, arready[g], rvalid[g], rlast[g], rresp[g], rid[g], mem_en[g]);
                    end
                    rst_seen[g] = 1'b1;
                end
                exp_q[g].delete();
                exp_mem[g].delete();
                first_pend[g] = 0; chk_bub[g] = 0; chk_ar[g] = 0; hold_v[g] = 0;
                post_rst[g] = 1;
            end else begin
                rst_seen[g] = 1'b0;
                if (post_rst[g] != 0) begin
                    n_checks++;
                    if (arready[g] != (post_rst[g] == 2)) begin
                        n_fail++;
                        $display("FAIL arready_after_reset[%0d] step=%0d got %b want %b",
                                 g, post_rst[g], arready[g], post_rst[g] == 2);
                    end
                    post_rst[g] = (post_rst[g] == 1) ? 2 : 0;
                end
                if (arvalid[g] && arready[g]) begin
                    hs_edge[g] = cyc + 1;
                    first_pend[g] = 1'b1;
                end
                if (chk_bub[g]) begin
                    n_checks++;
                    if (rvalid[g]) begin
                        n_fail++;
                        $display("FAIL req_bubble[%0d] got rvalid=1 want 0", g);
                    end
                    chk_bub[g] = 1'b0;
                end
                if (chk_ar[g]) begin
                    n_checks++;
                    if (!arready[g]) begin
                        n_fail++;
                        $display("FAIL arready_after_rlast[%0d] got 0 want 1", g);
                    end
                    chk_ar[g] = 1'b0;
                end
                if (hold_v[g]) begin
                    n_checks++;
                    if (!rvalid[g] || cur != hold_b[g]) begin
                        n_fail++;
                        $display("FAIL stall_hold[%0d] got rvalid=%b beat=%h want rvalid=1 beat=%h",
                                 g, rvalid[g], cur, hold_b[g]);
                    end
                    hold_v[g] = 1'b0;
                end
                if (rvalid[g] && first_pend[g]) begin
                    n_checks++;
                    if (cyc != hs_edge[g] + 1 + g * 4) begin
                        n_fail++;
                        $display("FAIL first_latency[%0d] got edge %0d want edge %0d",
                                 g, cyc - hs_edge[g], 1 + g * 4);
                    end
                    first_pend[g] = 1'b0;
                end
                if (mem_en[g]) begin
                    n_checks++;
                    if (exp_mem[g].size() == 0) begin
                        n_fail++;
                        $display("FAIL mem_en[%0d] got read of word %0d want no read", g, mem_addr[g]);
                    end else if (mem_addr[g] != exp_mem[g][0]) begin
                        n_fail++;
                        $display("FAIL mem_addr[%0d] got %0d want %0d", g, mem_addr[g], exp_mem[g][0]);
                        void'(exp_mem[g].pop_front());
                    end else begin
                        void'(exp_mem[g].pop_front());
                    end
                end
                if (rvalid[g] && rready[g]) begin
                    n_checks++;
                    if (exp_q[g].size() == 0) begin
                        n_fail++;
                        $display("FAIL beat[%0d] got unexpected beat %h want none", g, cur);
                    end else begin
                        want = exp_q[g].pop_front();
                        if (cur != want) begin
                            n_fail++;
                            $display("FAIL beat[%0d] got data=%h resp=%b last=%b id=%h want data=%h resp=%b last=%b id=%h",
                                     g, cur.data, cur.resp, cur.last, cur.id,
                                     want.data, want.resp, want.last, want.id);
                        end
                    end
                    if (rlast[g]) chk_ar[g] = 1'b1;
                    else          chk_bub[g] = 1'b1;
                end else if (rvalid[g]) begin
                    hold_b[g] = cur;
                    hold_v[g] = 1'b1;
                end
            end
        end
        if (tmo_cnt != tmo_seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout got %0d expired waits want 0", tmo_cnt - tmo_seen);
            tmo_seen = tmo_cnt;
        end
    end

    task automatic exp_beat(input int g, input logic [31:0] d, input logic [1:0] r,
                            input logic l, input logic [3:0] id);
        beat_t b;
        b = '{d, r, l, id};
        exp_q[g].push_back(b);
    endtask

    task automatic exp_word(input int g, input int w);
        exp_mem[g].push_back(MEM_AW'(w));
    endtask

    task automatic ar(input int g, input logic [3:0] i_id, input logic [7:0] i_len,
                      input logic [2:0] i_size, input logic [1:0] i_burst, input logic [31:0] i_addr);
        int n;
        @(posedge clk); #1;
        arid[g] = i_id; arlen[g] = i_len; arsize[g] = i_size;
        arburst[g] = i_burst; araddr[g] = i_addr; arvalid[g] = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (arready[g]) break;
        end
        if (n == 100) tmo_cnt++;
        @(posedge clk); #1;
        arvalid[g] = 1'b0;
    endtask

    task automatic wait_done(input int g);
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (exp_q[g].size() == 0 && exp_mem[g].size() == 0) break;
        end
        if (n == 400) tmo_cnt++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 16384; i++) mem[i] = {16'hC0DE, 16'(i)};
        mem[0] = 32'h0000_0413;
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; arvalid[g] = 1'b0; arid[g] = '0; arlen[g] = '0;
            arsize[g] = '0; arburst[g] = '0; araddr[g] = '0;
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst[0] = 1'b0; rst[1] = 1'b0;
        repeat (4) @(negedge clk);

        // Fetch-unit request.
        exp_word(0, 0); exp_beat(0, 32'h0000_0413, 2'b00, 1, 4'h0);
        ar(0, 4'h0, 8'd0, 3'd2, 2'b00, 32'h2000_0000); wait_done(0);

        // INCR x4 with random stalls.
        rdy_mode[0] = 1;
        for (int i = 0; i < 4; i++) begin
            exp_word(0, 4 + i); exp_beat(0, 32'hC0DE_0004 + i, 2'b00, i == 3, 4'h3);
        end
        ar(0, 4'h3, 8'd3, 3'd2, 2'b01, 32'h2000_0010); wait_done(0);
        rdy_mode[0] = 0;

        // WRAP x4 from 0x18: words 6,7,4,5.
        exp_word(0, 6); exp_beat(0, 32'hC0DE_0006, 2'b00, 0, 4'h5);
        exp_word(0, 7); exp_beat(0, 32'hC0DE_0007, 2'b00, 0, 4'h5);
        exp_word(0, 4); exp_beat(0, 32'hC0DE_0004, 2'b00, 0, 4'h5);
        exp_word(0, 5); exp_beat(0, 32'hC0DE_0005, 2'b00, 1, 4'h5);
        ar(0, 4'h5, 8'd3, 3'd2, 2'b10, 32'h2000_0018); wait_done(0);

        // Below-base first beat, then word 0.
        exp_beat(0, 32'h0, 2'b10, 0, 4'h1);
        exp_word(0, 0); exp_beat(0, 32'h0000_0413, 2'b00, 1, 4'h1);
        ar(0, 4'h1, 8'd1, 3'd2, 2'b01, 32'h1FFF_FFFC); wait_done(0);

        // Oversized beats: whole burst errors.
        exp_beat(0, 32'h0, 2'b10, 0, 4'h2); exp_beat(0, 32'h0, 2'b10, 1, 4'h2);
        ar(0, 4'h2, 8'd1, 3'd3, 2'b01, 32'h1FFF_FFFC); wait_done(0);

        // Reserved burst type.
        exp_beat(0, 32'h0, 2'b10, 1, 4'h7);
        ar(0, 4'h7, 8'd0, 3'd2, 2'b11, 32'h2000_0000); wait_done(0);

        // WRAP with illegal length 3 beats.
        exp_beat(0, 32'h0, 2'b10, 0, 4'h6); exp_beat(0, 32'h0, 2'b10, 0, 4'h6);
        exp_beat(0, 32'h0, 2'b10, 1, 4'h6);
        ar(0, 4'h6, 8'd2, 3'd2, 2'b10, 32'h2000_0000); wait_done(0);

        // WRAP misaligned start.
        exp_beat(0, 32'h0, 2'b10, 0, 4'h8); exp_beat(0, 32'h0, 2'b10, 1, 4'h8);
        ar(0, 4'h8, 8'd1, 3'd2, 2'b10, 32'h2000_0002); wait_done(0);

        // FIXED x3 repeats word 2, with stalls.
        rdy_mode[0] = 1;
        for (int i = 0; i < 3; i++) begin
            exp_word(0, 2); exp_beat(0, 32'hC0DE_0002, 2'b00, i == 2, 4'h4);
        end
        ar(0, 4'h4, 8'd2, 3'd2, 2'b00, 32'h2000_0008); wait_done(0);
        rdy_mode[0] = 0;

        // Top word of memory, then one past the end.
        exp_word(0, 16383); exp_beat(0, 32'hC0DE_3FFF, 2'b00, 0, 4'hF);
        exp_beat(0, 32'h0, 2'b10, 1, 4'hF);
        ar(0, 4'hF, 8'd1, 3'd2, 2'b01, 32'h2000_FFFC); wait_done(0);

        // Delayed instance: single beat with id 0xA.
        exp_word(1, 1); exp_beat(1, 32'hC0DE_0001, 2'b00, 1, 4'hA);
        ar(1, 4'hA, 8'd0, 3'd2, 2'b00, 32'h2000_0004); wait_done(1);

        // Delayed instance: reset while beat 2 of 4 is presented.
        for (int i = 0; i < 4; i++) begin
            exp_word(1, 8 + i); exp_beat(1, 32'hC0DE_0008 + i, 2'b00, i == 3, 4'hA);
        end
        ar(1, 4'hA, 8'd3, 3'd2, 2'b01, 32'h2000_0020);
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (exp_q[1].size() == 3) break;
        end
        if (n == 100) tmo_cnt++;
        rdy_mode[1] = 2;
        for (n = 0; n < 100; n++) begin
            @(posedge clk); #2;
            if (rvalid[1]) break;
        end
        if (n == 100) tmo_cnt++;
        rst[1] = 1'b1;
        @(posedge clk); #2;
        rst[1] = 1'b0;
        rdy_mode[1] = 0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
